// File: rtl/uart_pkg.sv
// Shared constants for the UART receive front end: FSM encoding and default frame geometry.
// No logic, no latency, no backpressure.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_WIDTH   = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a selectable reset level; 2 cycles latency.
// No backpressure: samples every cycle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// UART frame receiver feeding a parallel register; load_signal ~154 cycles after the start edge.
// No backpressure: the downstream register must accept every one-cycle load strobe.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  load_signal,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic                  rx;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_output <= '0;
      load_signal <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      load_signal <= 1'b0;
      frame_error <= 1'b0;
      cnt         <= cnt + CNT_ONE;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx) state <= S_START;
        end
        S_START: begin
          // Mid start bit: a line back high here was a glitch, not a frame.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx, shreg[DATA_WIDTH-1:1]};
            idx   <= idx + IDX_ONE;
            if (idx == IDX_LAST) state <= S_STOP;
          end
        end
        S_STOP: begin
          // Returning to IDLE at the stop-bit centre leaves half a bit to catch a back-to-back start.
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx) begin
              data_output <= shreg;
              load_signal <= 1'b1;
              state       <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader with a downstream 8-bit register model.
module tb_uart_rx_loader;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          serial_in;
  logic [DW-1:0] data_output;
  logic          load_signal;
  logic          frame_error;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int load_cnt = 0, fe_cnt = 0, long_pulse = 0, overlap = 0, busy_miss = 0, reg_bad = 0;
  int last_load_cyc = 0;
  logic [DW-1:0] ld_q[$];
  logic          load_prev = 1'b0, fe_prev = 1'b0;
  logic [DW-1:0] reg_q, reg_last, reg_after;

  always #5 clk = ~clk;

  uart_rx_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_output (data_output),
    .load_signal (load_signal),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream register: captures data_output on load_signal.
  always_ff @(posedge clk) begin
    if (reset) reg_q <= '0;
    else if (load_signal) reg_q <= data_output;
  end

  always @(negedge clk) begin
    if (load_signal) begin
      load_cnt++;
      ld_q.push_back(data_output);
      last_load_cyc = cyc;
      if (load_prev) long_pulse++;
    end
    if (frame_error) begin
      fe_cnt++;
      if (fe_prev) long_pulse++;
    end
    if (load_signal && frame_error) overlap++;
    if (load_prev) reg_after = reg_q;
    else if (!reset && reg_q !== reg_last) reg_bad++;
    reg_last  = reg_q;
    load_prev = load_signal;
    fe_prev   = frame_error;
  end

  task automatic drive_bit(input logic b, input logic chk);
    serial_in = b;
    repeat (CPB / 2) @(posedge clk);
    @(negedge clk);
    if (chk && !busy) busy_miss++;
    repeat (CPB / 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop, output int start_cyc);
    logic [DW-1:0] v;
    v = b;
    start_cyc = cyc;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < DW; i++) drive_bit(v[i], 1'b1);
    drive_bit(stop, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (data_output !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_output); end
    checks++; if (load_signal !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load_signal); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int l0, f0, s, lat;
    l0 = load_cnt; f0 = fe_cnt; busy_miss = 0;
    send_frame(8'h55, 1'b1, s);
    repeat (4) @(posedge clk); #1;
    lat = last_load_cyc - s;
    checks++; if (load_cnt - l0 !== 1) begin failures++; $display("FAIL single_loads got=%0d exp=1", load_cnt - l0); end
    checks++; if (ld_q[l0] !== 8'b01010101) begin failures++; $display("FAIL single_data got=%h exp=55", ld_q[l0]); end
    checks++; if (fe_cnt !== f0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt - f0); end
    checks++; if (lat < 153 || lat > 155) begin failures++; $display("FAIL single_latency got=%0d exp=153..155", lat); end
    checks++; if (busy_miss !== 0) begin failures++; $display("FAIL single_busy low_samples=%0d exp=0", busy_miss); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int l0, s;
    l0 = load_cnt; busy_miss = 0;
    send_frame(8'hA3, 1'b1, s);
    send_frame(8'h0F, 1'b1, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (load_cnt - l0 !== 2) begin failures++; $display("FAIL b2b_loads got=%0d exp=2", load_cnt - l0); end
    else begin
      checks++; if (ld_q[l0] !== 8'hA3) begin failures++; $display("FAIL b2b_first got=%h exp=a3", ld_q[l0]); end
      checks++; if (ld_q[l0+1] !== 8'h0F) begin failures++; $display("FAIL b2b_second got=%h exp=0f", ld_q[l0+1]); end
    end
    checks++; if (busy_miss !== 0) begin failures++; $display("FAIL b2b_busy low_samples=%0d exp=0", busy_miss); end
  endtask

  task automatic test_glitch;
    int l0, f0;
    logic idle_ok;
    l0 = load_cnt; f0 = fe_cnt; idle_ok = 1'b0;
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 serial_in = 1'b1;
    for (int i = 0; i < CPB / 2 + 3; i++) begin
      @(negedge clk);
      if (!busy) begin idle_ok = 1'b1; break; end
    end
    checks++; if (!idle_ok) begin failures++; $display("FAIL glitch_busy got=1 exp=0 within %0d cycles", CPB / 2 + 3); end
    repeat (2 * CPB) @(posedge clk); #1;
    checks++; if (load_cnt !== l0) begin failures++; $display("FAIL glitch_load got=%0d exp=0", load_cnt - l0); end
    checks++; if (fe_cnt !== f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_break;
    int l0, f0, s;
    send_frame(8'h55, 1'b1, s);
    l0 = load_cnt; f0 = fe_cnt;
    send_frame(8'h81, 1'b0, s);
    repeat (64) @(posedge clk); #1;
    checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL break_ferr got=%0d exp=1", fe_cnt - f0); end
    checks++; if (load_cnt !== l0) begin failures++; $display("FAIL break_load got=%0d exp=0", load_cnt - l0); end
    checks++; if (data_output !== 8'h55) begin failures++; $display("FAIL break_data got=%h exp=55", data_output); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_hold_busy got=%b exp=1", busy); end
    serial_in = 1'b1;
    repeat (CPB) @(posedge clk); #1;
    send_frame(8'h3C, 1'b1, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (load_cnt - l0 !== 1) begin failures++; $display("FAIL break_recover_loads got=%0d exp=1", load_cnt - l0); end
    checks++; if (data_output !== 8'h3C) begin failures++; $display("FAIL break_recover_data got=%h exp=3c", data_output); end
  endtask

  task automatic test_reset_mid_frame;
    int l0, s;
    l0 = load_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    serial_in = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (data_output !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_output); end
    checks++; if (load_signal !== 1'b0) begin failures++; $display("FAIL rstmid_load got=%b exp=0", load_signal); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", frame_error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (CPB / 2 - 1) @(posedge clk); #1;
    for (int i = 4; i < DW; i++) drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    checks++; if (load_cnt !== l0) begin failures++; $display("FAIL rstmid_noload got=%0d exp=0", load_cnt - l0); end
    send_frame(8'h3C, 1'b1, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (data_output !== 8'h3C) begin failures++; $display("FAIL rstmid_next_data got=%h exp=3c", data_output); end
  endtask

  task automatic test_register;
    int s;
    reg_bad = 0;
    send_frame(8'h55, 1'b1, s);
    repeat (4) @(posedge clk); #1;
    checks++; if (reg_after !== 8'b01010101) begin failures++; $display("FAIL reg_capture got=%h exp=55", reg_after); end
    checks++; if (reg_q !== 8'h55) begin failures++; $display("FAIL reg_hold got=%h exp=55", reg_q); end
    checks++; if (reg_bad !== 0) begin failures++; $display("FAIL reg_stable changes_without_load=%0d exp=0", reg_bad); end
  endtask

  task automatic test_strobes;
    checks++; if (long_pulse !== 0) begin failures++; $display("FAIL strobe_width long_pulses=%0d exp=0", long_pulse); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid_frame;
    test_register;
    test_strobes;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
